// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-generator pipeline: opcode constants,
// the format code enumeration and parameter legality helpers.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32'sd32) || (xlen == 32'sd64);
  endfunction

  function automatic bit depth_legal(input int depth);
    return (depth >= 32'sd1) && (depth <= 32'sd4);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational opcode decode and immediate assembly, sign-extended from
// instr[31] to XLEN bits.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output imm_fmt_e        o_fmt
);

  logic [31:0] imm32_s;

  // Decode the format and build a 32-bit sign-extended immediate.
  always_comb begin
    o_fmt   = FMT_NONE;
    imm32_s = 32'd0;
    case (i_instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: begin
        o_fmt   = FMT_I;
        imm32_s = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      OPC_OP_IMM_32: begin
        // the W-form immediates only exist on RV64
        if (XLEN == 32'sd64) begin
          o_fmt   = FMT_I;
          imm32_s = {{20{i_instr[31]}}, i_instr[31:20]};
        end else begin
          o_fmt   = FMT_NONE;
          imm32_s = 32'd0;
        end
      end
      OPC_STORE: begin
        o_fmt   = FMT_S;
        imm32_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      OPC_BRANCH: begin
        o_fmt   = FMT_B;
        imm32_s = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        o_fmt   = FMT_U;
        imm32_s = {i_instr[31:12], 12'd0};
      end
      OPC_JAL: begin
        o_fmt   = FMT_J;
        imm32_s = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      end
      default: begin
        o_fmt   = FMT_NONE;
        imm32_s = 32'd0;
      end
    endcase
  end

  assign o_imm = XLEN'($signed(imm32_s));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator: decode at the input, then a DEPTH-stage elastic
// register pipeline with valid/ready handshakes on both sides and a flush.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_fmt
);

  if (!xlen_legal(XLEN) || !depth_legal(DEPTH)) begin : g_bad_param
    $error("imm_gen_pipe: XLEN must be 32 or 64 and DEPTH 1..4");
  end

  logic [XLEN-1:0] ext_imm_s;
  imm_fmt_e        ext_fmt_s;
  logic            accept_s;
  logic [DEPTH-1:0] load_s;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [XLEN-1:0]  imm_q [DEPTH];
  logic [XLEN-1:0]  imm_d [DEPTH];
  imm_fmt_e         fmt_q [DEPTH];
  imm_fmt_e         fmt_d [DEPTH];

  imm_extract #(.XLEN(XLEN)) u_extract (
    .i_instr (i_instr),
    .o_imm   (ext_imm_s),
    .o_fmt   (ext_fmt_s)
  );

  // A stage may load when it is empty or its successor loads this cycle.
  always_comb begin
    logic chain;
    load_s = '0;
    chain  = !vld_q[DEPTH-1] || i_ready;
    load_s[DEPTH-1] = chain;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      chain     = !vld_q[k] || chain;
      load_s[k] = chain;
    end
  end

  assign o_ready  = !i_flush && load_s[0];
  assign accept_s = i_valid && o_ready;

  // Next-state for every stage; flush wins over any movement.
  always_comb begin
    vld_d = vld_q;
    imm_d = imm_q;
    fmt_d = fmt_q;
    if (i_flush) begin
      vld_d = '0;
    end else begin
      if (load_s[0]) begin
        vld_d[0] = accept_s;
        imm_d[0] = ext_imm_s;
        fmt_d[0] = ext_fmt_s;
      end else begin
        vld_d[0] = vld_q[0];
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (load_s[k]) begin
          vld_d[k] = vld_q[k-1];
          imm_d[k] = imm_q[k-1];
          fmt_d[k] = fmt_q[k-1];
        end else begin
          vld_d[k] = vld_q[k];
        end
      end
    end
  end

  // Stage registers; reset clears data too so outputs read zero/NONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        imm_q[k] <= '0;
        fmt_q[k] <= FMT_NONE;
      end
    end else begin
      vld_q <= vld_d;
      imm_q <= imm_d;
      fmt_q <= fmt_d;
    end
  end

  assign o_valid = vld_q[DEPTH-1];
  assign o_imm   = imm_q[DEPTH-1];
  assign o_fmt   = fmt_q[DEPTH-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance driven in
// lockstep, checked against spec constants and an arithmetic reference model.
module tb_imm_gen_pipe;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] e32;
    logic [63:0] e64;
    logic [2:0]  f32;
    logic [2:0]  f64;
    int          t;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        valid;
  logic        rdy;
  logic [31:0] instr;
  logic        ordy32, ov32, ordy64, ov64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;

  sb_t  q[$];
  sb_t  tab[9];
  sb_t  idle;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic acc_last;
  int   bp;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(ordy32),
    .i_instr(instr), .o_valid(ov32), .i_ready(rdy), .o_imm(imm32), .o_fmt(fmt32)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(ordy64),
    .i_instr(instr), .o_valid(ov64), .i_ready(rdy), .o_imm(imm64), .o_fmt(fmt64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: immediate value from field weights, then wrapped to xlen bits.
  function automatic void ref_val(input logic [31:0] ins, input int xlen,
                                  output logic [63:0] imm, output logic [2:0] fmt);
    longint v;
    v   = 64'sd0;
    fmt = 3'd0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: fmt = 3'd1;
      7'h1B:                      fmt = (xlen == 64) ? 3'd1 : 3'd0;
      7'h23:                      fmt = 3'd2;
      7'h63:                      fmt = 3'd3;
      7'h37, 7'h17:               fmt = 3'd4;
      7'h6F:                      fmt = 3'd5;
      default:                    fmt = 3'd0;
    endcase
    case (fmt)
      3'd1: begin
        v = longint'(ins[31:20]);
        if (v >= 64'sd2048) v = v - 64'sd4096;
      end
      3'd2: begin
        v = longint'(ins[31:25]) * 64'sd32 + longint'(ins[11:7]);
        if (v >= 64'sd2048) v = v - 64'sd4096;
      end
      3'd3: begin
        v = longint'(ins[31]) * 64'sd4096 + longint'(ins[7]) * 64'sd2048
          + longint'(ins[30:25]) * 64'sd32 + longint'(ins[11:8]) * 64'sd2;
        if (v >= 64'sd4096) v = v - 64'sd8192;
      end
      3'd4: begin
        v = longint'(ins[31:12]) * 64'sd4096;
        if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
      end
      3'd5: begin
        v = longint'(ins[31]) * 64'sd1048576 + longint'(ins[19:12]) * 64'sd4096
          + longint'(ins[20]) * 64'sd2048 + longint'(ins[30:21]) * 64'sd2;
        if (v >= 64'sd1048576) v = v - 64'sd2097152;
      end
      default: v = 64'sd0;
    endcase
    imm = (xlen == 32) ? {32'h0, v[31:0]} : v;
  endfunction

  function automatic sb_t mk(input logic [31:0] ins, input logic [63:0] e32, input logic [63:0] e64,
                             input logic [2:0] f32, input logic [2:0] f64);
    sb_t e;
    e.ins = ins; e.e32 = e32; e.e64 = e64; e.f32 = f32; e.f64 = f64; e.t = 0;
    return e;
  endfunction

  function automatic sb_t model_entry(input logic [31:0] ins);
    sb_t e;
    e.ins = ins;
    e.t   = 0;
    ref_val(ins, 32, e.e32, e.f32);
    ref_val(ins, 64, e.e64, e.f64);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(11, 0))
      0:  r[6:0] = 7'h03;
      1:  r[6:0] = 7'h13;
      2:  r[6:0] = 7'h67;
      3:  r[6:0] = 7'h73;
      4:  r[6:0] = 7'h1B;
      5:  r[6:0] = 7'h23;
      6:  r[6:0] = 7'h63;
      7:  r[6:0] = 7'h37;
      8:  r[6:0] = 7'h17;
      9:  r[6:0] = 7'h6F;
      10: r[6:0] = 7'h33;
      default: r[6:0] = r[6:0];
    endcase
    return r;
  endfunction

  // One clock cycle: drive at negedge, check before the posedge, update model after it.
  task automatic cycle(input logic v, input logic fl, input logic r, input sb_t e);
    int   n;
    logic exp_rdy, exp_ov, acc, xfer;
    valid = v; instr = e.ins; rdy = r; flush = fl;
    #1;
    n       = q.size();
    exp_rdy = !fl && ((n < DEPTH) || r);
    exp_ov  = (n > 0) && ((cyc - q[0].t) >= DEPTH);
    chk("o_ready32", 64'(ordy32), 64'(exp_rdy));
    chk("o_ready64", 64'(ordy64), 64'(exp_rdy));
    chk("o_valid32", 64'(ov32), 64'(exp_ov));
    chk("o_valid64", 64'(ov64), 64'(exp_ov));
    if (exp_ov) begin
      chk("o_imm32", {32'h0, imm32}, q[0].e32);
      chk("o_imm64", imm64, q[0].e64);
      chk("o_fmt32", 64'(fmt32), 64'(q[0].f32));
      chk("o_fmt64", 64'(fmt64), 64'(q[0].f64));
    end
    acc      = v && exp_rdy;
    xfer     = exp_ov && r && !fl;
    acc_last = acc;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (xfer) void'(q.pop_front());
      if (acc) begin
        e.t = cyc;
        q.push_back(e);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    tab[0] = mk(32'hFFF00093, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1);
    tab[1] = mk(32'hFE112E23, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 3'd2);
    tab[2] = mk(32'h00000863, 64'h00000010, 64'h0000000000000010, 3'd3, 3'd3);
    tab[3] = mk(32'h123452B7, 64'h12345000, 64'h0000000012345000, 3'd4, 3'd4);
    tab[4] = mk(32'hFF9FF06F, 64'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd5, 3'd5);
    tab[5] = mk(32'h800002B7, 64'h80000000, 64'hFFFFFFFF80000000, 3'd4, 3'd4);
    tab[6] = mk(32'h0000001B, 64'h0,        64'h0,                3'd0, 3'd1);
    tab[7] = mk(32'h0010809B, 64'h0,        64'h1,                3'd0, 3'd1);
    tab[8] = mk(32'h00000033, 64'h0,        64'h0,                3'd0, 3'd0);
    idle   = mk(32'h0, 64'h0, 64'h0, 3'd0, 3'd0);

    rst_n = 1'b0; flush = 1'b0; valid = 1'b0; rdy = 1'b1; instr = 32'h0;
    @(negedge clk);
    chk("rst_valid32", 64'(ov32), 64'd0);
    chk("rst_valid64", 64'(ov64), 64'd0);
    chk("rst_imm32", {32'h0, imm32}, 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_fmt32", 64'(fmt32), 64'd0);
    chk("rst_fmt64", 64'(fmt64), 64'd0);
    rst_n = 1'b1;

    // Back-to-back directed vectors with i_ready high, then drain.
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b1, tab[i]);
    repeat (DEPTH + 2) cycle(1'b0, 1'b0, 1'b1, idle);

    // Backpressure from empty: only DEPTH words may be taken.
    bp = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, model_entry(rand_instr()));
      if (acc_last) bp++;
    end
    chk("bp_accepted", 64'(bp), 64'd2);
    repeat (DEPTH + 2) cycle(1'b0, 1'b0, 1'b1, idle);

    // Flush a full pipeline while i_valid is high, then refill.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, model_entry(rand_instr()));
    cycle(1'b1, 1'b1, 1'b1, model_entry(rand_instr()));
    cycle(1'b1, 1'b0, 1'b1, tab[3]);
    repeat (DEPTH + 2) cycle(1'b0, 1'b0, 1'b1, idle);

    // Full pipeline, then i_ready and i_valid together shift it.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, model_entry(rand_instr()));
    repeat (4) cycle(1'b1, 1'b0, 1'b1, model_entry(rand_instr()));
    repeat (DEPTH + 2) cycle(1'b0, 1'b0, 1'b1, idle);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(3, 0) != 0), ($urandom_range(29, 0) == 0),
            ($urandom_range(2, 0) != 0), model_entry(rand_instr()));
    end
    repeat (DEPTH + 2) cycle(1'b0, 1'b0, 1'b1, idle);

    // Asynchronous reset between edges with a full pipeline.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, model_entry(rand_instr()));
    valid = 1'b1; rdy = 1'b0; flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid32", 64'(ov32), 64'd0);
    chk("async_valid64", 64'(ov64), 64'd0);
    chk("async_imm32", {32'h0, imm32}, 64'd0);
    chk("async_imm64", imm64, 64'd0);
    chk("async_fmt32", 64'(fmt32), 64'd0);
    chk("async_fmt64", 64'(fmt64), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 1'b1, idle);
    cycle(1'b1, 1'b0, 1'b1, tab[4]);
    repeat (DEPTH + 2) cycle(1'b0, 1'b0, 1'b1, idle);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
